// File: rtl/memarb.sv
`default_nettype none
// ============================================================================
//  Module      : memarb
//  Description : Single-port memory arbiter between the fetch requester (I)
//                and the load/store requester (D). The data port has
//                priority. A streak limiter stops D from holding off a
//                waiting fetch for more than P_MAX_DSTREAK grants in a row.
//                Read data returns to the owning requester one cycle after
//                its grant. A saturating counter records fetch stall cycles
//                for debug.
//  Revision    : 1.0 - initial release
// ============================================================================
module memarb #(
    parameter int P_MAX_DSTREAK = 3,
    parameter int P_CNT_W       = 16,
    parameter int SIZE_ADDR     = 8,
    parameter int SIZE_DATA     = 16
) (
    input  logic                 iw_clk,
    input  logic                 iw_rst,

    // Fetch requester (read only)
    input  logic                 iw_i_req,
    input  logic [SIZE_ADDR-1:0] iw_i_addr,
    output logic                 ow_i_gnt,
    output logic                 ow_i_rvalid,
    output logic [SIZE_DATA-1:0] ow_i_rdata,
    output logic                 ow_i_stall,

    // Data requester (read / write)
    input  logic                 iw_d_req,
    input  logic                 iw_d_we,
    input  logic [SIZE_ADDR-1:0] iw_d_addr,
    input  logic [SIZE_DATA-1:0] iw_d_wdata,
    output logic                 ow_d_gnt,
    output logic                 ow_d_rvalid,
    output logic [SIZE_DATA-1:0] ow_d_rdata,

    // Memory port (synchronous read, one cycle latency)
    output logic                 ow_mem_we,
    output logic [SIZE_ADDR-1:0] ow_mem_addr,
    output logic [SIZE_DATA-1:0] ow_mem_wdata,
    input  logic [SIZE_DATA-1:0] iw_mem_rdata,

    // Debug
    output logic [P_CNT_W-1:0]   ow_i_stall_cnt
);

    // Streak limit held in the same width as the streak register.
    localparam logic [3:0]         C_MAX_STREAK = 4'(P_MAX_DSTREAK);
    localparam logic [P_CNT_W-1:0] C_CNT_MAX    = {P_CNT_W{1'b1}};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [3:0]         r_dstreak;    // consecutive D grants while I waits
    logic               r_rsp_i;      // fetch read issued last cycle
    logic               r_rsp_d;      // data read issued last cycle
    logic [P_CNT_W-1:0] r_stall_cnt;  // saturating fetch stall count

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic               w_i_gnt;
    logic               w_d_gnt;
    logic               w_force_i;
    logic               w_i_stall;
    logic [3:0]         w_dstreak_nxt;
    logic [SIZE_ADDR-1:0] w_mem_addr;
    logic [SIZE_DATA-1:0] w_mem_wdata;

    // Fetch is forced through once D has used up its allowed streak.
    assign w_force_i = (r_dstreak >= C_MAX_STREAK);

    // Grant selection: D wins contention unless the streak limit is reached.
    always_comb begin
        w_i_gnt = 1'b0;
        w_d_gnt = 1'b0;
        if (!iw_rst) begin
            if (iw_i_req && (!iw_d_req || w_force_i)) begin
                w_i_gnt = 1'b1;
            end else if (iw_d_req) begin
                w_d_gnt = 1'b1;
            end
        end
    end

    // A stall is a live fetch request that lost this cycle; nothing stalls
    // during reset because requests are ignored then.
    assign w_i_stall = iw_i_req & ~w_i_gnt & ~iw_rst;

    // Memory address / write data come from whichever port owns the cycle.
    // Fetch carries no write data, so the data bus idles at zero for it.
    always_comb begin
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        if (w_d_gnt) begin
            w_mem_addr  = iw_d_addr;
            w_mem_wdata = iw_d_wdata;
        end else if (w_i_gnt) begin
            w_mem_addr  = iw_i_addr;
        end
    end

    // Streak grows only while D beats a waiting fetch; capped at the limit.
    always_comb begin
        w_dstreak_nxt = 4'd0;
        if (w_d_gnt && iw_i_req) begin
            if (r_dstreak < C_MAX_STREAK) begin
                w_dstreak_nxt = r_dstreak + 4'd1;
            end else begin
                w_dstreak_nxt = C_MAX_STREAK;
            end
        end
    end

    // Streak register.
    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            r_dstreak <= 4'd0;
        end else begin
            r_dstreak <= w_dstreak_nxt;
        end
    end

    // Response-pending flags; writes produce no response. Reset drops any
    // read still in flight.
    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            r_rsp_i <= 1'b0;
            r_rsp_d <= 1'b0;
        end else begin
            r_rsp_i <= w_i_gnt;
            r_rsp_d <= w_d_gnt & ~iw_d_we;
        end
    end

    // Fetch stall counter: counts lost cycles, holds at all-ones.
    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            r_stall_cnt <= '0;
        end else if (w_i_stall && (r_stall_cnt != C_CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ow_i_gnt       = w_i_gnt;
    assign ow_d_gnt       = w_d_gnt;
    assign ow_i_stall     = w_i_stall;

    assign ow_mem_we      = w_d_gnt & iw_d_we;
    assign ow_mem_addr    = w_mem_addr;
    assign ow_mem_wdata   = w_mem_wdata;

    // Read data is steered to its owner only; the other side sees zero.
    assign ow_i_rvalid    = r_rsp_i;
    assign ow_i_rdata     = r_rsp_i ? iw_mem_rdata : '0;
    assign ow_d_rvalid    = r_rsp_d;
    assign ow_d_rdata     = r_rsp_d ? iw_mem_rdata : '0;

    assign ow_i_stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_memarb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_memarb
//  Description : Self-checking bench for memarb with an attached memory model
//                and a behavioural reference of the arbitration rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_memarb;

    localparam int MAXS = 3;
    localparam int CW   = 4;
    localparam int AW   = 8;
    localparam int DW   = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_gnt, i_rvalid, i_stall;
    logic [DW-1:0] i_rdata;
    logic          d_req, d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt, d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [CW-1:0] stall_cnt;

    always #5 clk = ~clk;

    memarb #(
        .P_MAX_DSTREAK (MAXS),
        .P_CNT_W       (CW),
        .SIZE_ADDR     (AW),
        .SIZE_DATA     (DW)
    ) dut (
        .iw_clk         (clk),
        .iw_rst         (rst),
        .iw_i_req       (i_req),
        .iw_i_addr      (i_addr),
        .ow_i_gnt       (i_gnt),
        .ow_i_rvalid    (i_rvalid),
        .ow_i_rdata     (i_rdata),
        .ow_i_stall     (i_stall),
        .iw_d_req       (d_req),
        .iw_d_we        (d_we),
        .iw_d_addr      (d_addr),
        .iw_d_wdata     (d_wdata),
        .ow_d_gnt       (d_gnt),
        .ow_d_rvalid    (d_rvalid),
        .ow_d_rdata     (d_rdata),
        .ow_mem_we      (mem_we),
        .ow_mem_addr    (mem_addr),
        .ow_mem_wdata   (mem_wdata),
        .iw_mem_rdata   (mem_rdata),
        .ow_i_stall_cnt (stall_cnt)
    );

    // Synchronous-read memory device driven by the arbiter.
    logic [DW-1:0] mem [256];
    always @(posedge clk) begin
        mem_rdata <= mem[mem_addr];
        if (mem_we) mem[mem_addr] = mem_wdata;
    end

    // Reference state: plain counters and a shadow copy of memory.
    logic [DW-1:0] shadow [256];
    int            m_streak;
    int            m_cnt;
    bit            m_rsp_i, m_rsp_d;
    logic [DW-1:0] m_data_i, m_data_d;
    bit            last_gi, last_gd;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: inputs are already applied; check all outputs against
    // the rules, then advance the reference across the rising edge.
    task automatic cycle();
        bit            gi, gd, stl;
        logic [AW-1:0] ea;
        #1;
        if (rst) begin
            gi = 0; gd = 0;
        end else if (i_req && d_req) begin
            gi = (m_streak >= MAXS);
            gd = !gi;
        end else begin
            gi = i_req; gd = d_req;
        end
        stl = i_req && !gi && !rst;
        ea  = gd ? d_addr : (gi ? i_addr : '0);
        chk("i_gnt",     i_gnt,    gi);
        chk("d_gnt",     d_gnt,    gd);
        chk("i_stall",   i_stall,  stl);
        chk("mem_we",    mem_we,   gd && d_we);
        chk("mem_addr",  mem_addr, ea);
        if (!gi) chk("mem_wdata", mem_wdata, gd ? d_wdata : '0);
        chk("i_rvalid",  i_rvalid, m_rsp_i);
        chk("i_rdata",   i_rdata,  m_rsp_i ? m_data_i : '0);
        chk("d_rvalid",  d_rvalid, m_rsp_d);
        chk("d_rdata",   d_rdata,  m_rsp_d ? m_data_d : '0);
        chk("stall_cnt", stall_cnt, m_cnt);
        @(posedge clk);
        if (rst) begin
            m_streak = 0; m_cnt = 0; m_rsp_i = 0; m_rsp_d = 0;
        end else begin
            m_streak = (gd && i_req) ? ((m_streak + 1 > MAXS) ? MAXS : m_streak + 1) : 0;
            m_rsp_i  = gi;
            m_data_i = shadow[i_addr];
            m_rsp_d  = gd && !d_we;
            m_data_d = shadow[d_addr];
            if (gd && d_we) shadow[d_addr] = d_wdata;
            if (stl && m_cnt < (1 << CW) - 1) m_cnt++;
        end
        last_gi = gi; last_gd = gd;
        @(negedge clk);
    endtask

    task automatic drive(input bit ir, input logic [AW-1:0] ia,
                         input bit dr, input bit we, input logic [AW-1:0] da,
                         input logic [DW-1:0] wd);
        i_req = ir; i_addr = ia; d_req = dr; d_we = we; d_addr = da; d_wdata = wd;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int k = 0; k < n; k++) cycle();
        rst = 1'b0;
    endtask

    initial begin
        int n;
        logic [7:0] pat;
        for (int a = 0; a < 256; a++) begin
            mem[a]    = DW'($urandom);
            shadow[a] = mem[a];
        end
        mem[8'h10] = 16'h0ABC; shadow[8'h10] = 16'h0ABC;
        m_streak = 0; m_cnt = 0; m_rsp_i = 0; m_rsp_d = 0;
        m_data_i = '0; m_data_d = '0;
        rst = 1'b1;
        drive(1, 8'h01, 1, 0, 8'h02, 16'h0);
        @(negedge clk);

        // Reset with both requests high: the model expects nothing granted.
        do_reset(2);
        chk("reset_cnt", stall_cnt, 0);

        // Fetch alone.
        drive(1, 8'h10, 0, 0, 8'h00, 16'h0);
        cycle();
        drive(0, 8'h00, 0, 0, 8'h00, 16'h0);
        #1 chk("fetch_rdata", i_rdata, 16'h0ABC);
        chk("fetch_d_rvalid", d_rvalid, 0);
        cycle();

        // Store then load of the same address.
        drive(0, 8'h00, 1, 1, 8'h20, 16'h0123);
        cycle();
        drive(0, 8'h00, 1, 0, 8'h20, 16'h0);
        #1 chk("store_no_rvalid", d_rvalid, 0);
        cycle();
        drive(0, 8'h00, 0, 0, 8'h00, 16'h0);
        #1 chk("load_rdata", d_rdata, 16'h0123);
        cycle();

        // Starvation bound: both requesting continuously.
        do_reset(1);
        pat = 8'b0111_0111;  // bit k = D granted in cycle k
        drive(1, 8'h30, 1, 0, 8'h40, 16'h0);
        for (int k = 0; k < 8; k++) begin
            #1 chk("starve_pat_d", d_gnt, pat[k]);
            cycle();
        end
        drive(0, 8'h00, 0, 0, 8'h00, 16'h0);
        #1 chk("starve_cnt", stall_cnt, 6);
        cycle();

        // Fetch request drops mid-streak: the streak restarts from zero.
        do_reset(1);
        drive(1, 8'h31, 1, 0, 8'h41, 16'h0);
        cycle(); cycle();
        drive(0, 8'h31, 1, 0, 8'h41, 16'h0);
        cycle();
        drive(1, 8'h31, 1, 0, 8'h41, 16'h0);
        n = 0;
        for (int k = 0; k < 10; k++) begin
            cycle();
            if (last_gi) break;
            n++;
        end
        chk("drop_wait", n, 3);

        // Saturation: long contention drives the counter to all-ones.
        do_reset(1);
        drive(1, 8'h32, 1, 0, 8'h42, 16'h0);
        for (int k = 0; k < 40; k++) cycle();
        drive(0, 8'h00, 0, 0, 8'h00, 16'h0);
        #1 chk("sat_cnt", stall_cnt, 15);
        cycle();

        // Randomised traffic with requesters holding until granted and an
        // occasional reset in the middle of activity.
        do_reset(1);
        last_gi = 1; last_gd = 1;
        for (int k = 0; k < 400; k++) begin
            rst = ($urandom_range(0, 49) == 0);
            if (!i_req || last_gi) begin
                i_req  = ($urandom_range(0, 3) != 0);
                i_addr = AW'($urandom);
            end
            if (!d_req || last_gd) begin
                d_req   = ($urandom_range(0, 2) != 0);
                d_we    = $urandom_range(0, 1) == 1;
                d_addr  = AW'($urandom_range(0, 15));
                d_wdata = DW'($urandom);
            end
            cycle();
        end
        rst = 1'b0;
        drive(0, 8'h00, 0, 0, 8'h00, 16'h0);
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/memarb.md
Name: memarb

Overview:
- Single-port memory arbiter between the core's instruction-address stage (fetch requester, "I") and its memory-access stage (load/store requester, "D").
- Drives the one synchronous-read port of mem; returns read data to the owning requester one cycle later.
- Data port has priority. A streak limiter bounds fetch starvation.
- Saturating stall counter for fetch exposes arbitration loss to debug.

Parameters:
- P_MAX_DSTREAK, 3: max consecutive D grants while I is pending before I is forced through (1..15).
- P_CNT_W, 16: width of the fetch-stall counter.

Ports:
- iw_clk  in  1  clock; all state updates on rising edge
- iw_rst  in  1  reset; synchronous, active-high
- iw_i_req  in  1  fetch read request
- iw_i_addr  in  SIZE_ADDR  fetch address
- ow_i_gnt  out  1  fetch granted this cycle (combinational)
- ow_i_rvalid  out  1  fetch read data valid (registered)
- ow_i_rdata  out  SIZE_DATA  fetch read data
- ow_i_stall  out  1  iw_i_req high and not granted (combinational)
- iw_d_req  in  1  data request
- iw_d_we  in  1  1 = write, 0 = read
- iw_d_addr  in  SIZE_ADDR  data address
- iw_d_wdata  in  SIZE_DATA  write data
- ow_d_gnt  out  1  data granted this cycle (combinational)
- ow_d_rvalid  out  1  data read valid (registered; never for writes)
- ow_d_rdata  out  SIZE_DATA  data read data
- ow_mem_we  out  1  to mem iw_we
- ow_mem_addr  out  SIZE_ADDR  to mem iw_addr
- ow_mem_wdata  out  SIZE_DATA  to mem iw_wdata
- iw_mem_rdata  in  SIZE_DATA  from mem or_rdata; valid one cycle after address
- ow_i_stall_cnt  out  P_CNT_W  saturating count of fetch stall cycles

Behaviour:
- State:
  - r_dstreak: 4-bit consecutive-D-grant count.
  - r_rsp_i, r_rsp_d: response-pending flags.
  - r_stall_cnt: fetch stall counter.
- Reset (iw_rst=1 at edge):
  - All state clears to 0.
  - While iw_rst is high, both gnts are 0, ow_mem_we is 0, and requests are ignored.
- Grant rules (combinational, iw_rst=0):
  - I only: I granted.
  - D only: D granted.
  - Both, r_dstreak < P_MAX_DSTREAK: D granted.
  - Both, r_dstreak == P_MAX_DSTREAK: I granted.
  - Neither: no grant.
  - Exactly one gnt at most per cycle. A requester holds req/addr/data stable until granted; there is no retraction rule.
- r_dstreak update:
  - D granted while iw_i_req=1: increment (never exceeds P_MAX_DSTREAK).
  - I granted, or iw_i_req=0: clear to 0.
- Memory drive:
  - ow_mem_addr/ow_mem_wdata come from the granted port.
  - With no grant: ow_mem_addr = 0, ow_mem_wdata = 0.
  - ow_mem_we = ow_d_gnt & iw_d_we.
- Response (latency 1):
  - r_rsp_i <= ow_i_gnt.
  - r_rsp_d <= ow_d_gnt & ~iw_d_we.
  - ow_x_rvalid = r_rsp_x.
  - ow_x_rdata = iw_mem_rdata when r_rsp_x, else 0.
  - Back-to-back grants give back-to-back rvalids. The previous response is never lost when ownership switches.
- Stall counter:
  - Increments each cycle ow_i_stall=1.
  - Saturates at all-ones, with no wrap.
  - Cleared only by reset.
- Reset mid-operation: a pending response is dropped; the rvalid after reset is 0.

Test Plan:
- Reset: assert iw_rst 2 cycles with both reqs high -> gnts 0, mem_we 0, rvalids 0, ow_i_stall_cnt 0.
- Fetch alone: i_req, addr 0x010, mem holds 0xABC at 0x010 -> i_gnt same cycle; next cycle i_rvalid=1, i_rdata=0xABC, d_rvalid=0.
- Store then load: D write 0x020<-0x123, then D read 0x020 -> mem_we=1 in cycle 1 only, no d_rvalid for the write; d_rvalid=1 with 0x123 in cycle 3.
- Starvation bound (P_MAX_DSTREAK=3), both requesting continuously -> grant pattern D,D,D,I,D,D,D,I; stall count 6 after 8 cycles; rvalids follow grants by one cycle.
- I request drops during the streak: D,D, then i_req low 1 cycle, then i_req high -> streak clears; I waits 3 further D grants.
- Saturation (P_CNT_W=4): hold i_req with D winning for 20 cycles -> ow_i_stall_cnt stops at 15.
